// File: rtl/kbd_irq_ctrl.sv
// kbd_irq_ctrl: keyboard byte FIFO with CPU interrupt handshake; define KBD_ACK_EDGE_EN for a level/edge-detected int_ack
module kbd_irq_ctrl #(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  key_valid,
   input  logic [7:0]            key_data,
   input  logic                  irq_en,
   input  logic                  int_ack,
   input  logic                  ovf_clr,
   output logic                  int_req,
   output logic [7:0]            kbd_ascii,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  ovf
);
   localparam int DEPTH = 2 ** DEPTH_LOG2;
   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
   state_t                state_q, state_d;
   logic [7:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  ovf_q, ovf_d, int_req_q;
   logic                  ack_ev, push, pop, full;
`ifdef KBD_ACK_EDGE_EN
   logic [2:0]            sync_q;
   // two-flop synchronizer plus a delayed copy for rising-edge detection
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[1:0], int_ack};
   assign ack_ev = sync_q[1] & ~sync_q[2];
`else
   assign ack_ev = int_ack;
`endif
   assign full = count_q == (DEPTH_LOG2 + 1)'(DEPTH);
   // pop only on an ack while requesting; a push at full is allowed when a pop frees the slot
   always_comb begin
      pop     = state_q == REQ && irq_en && ack_ev && count_q != '0;
      push    = key_valid && (!full || pop);
      count_d = count_q + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
      ovf_d   = (key_valid && full && !pop) || (ovf_q && !ovf_clr);
   end
   // interrupt handshake next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = (count_q != '0 && irq_en) ? REQ : IDLE;
         REQ:     state_d = !irq_en ? IDLE : pop ? HOLD : REQ;
         HOLD:    state_d = (count_q != '0 && irq_en) ? REQ : IDLE;
         default: state_d = IDLE;
      endcase
   end
   // control state, pointers, occupancy and flags
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= IDLE;
         int_req_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         int_req_q <= state_d == REQ;
         wr_ptr_q  <= wr_ptr_q + DEPTH_LOG2'(push);
         rd_ptr_q  <= rd_ptr_q + DEPTH_LOG2'(pop);
         count_q   <= count_d;
         ovf_q     <= ovf_d;
      end
   // storage is not reset; kbd_ascii is masked while empty
   always_ff @(posedge clk)
      if (push) mem_q[wr_ptr_q] <= key_data;
   assign int_req   = int_req_q;
   assign count     = count_q;
   assign ovf       = ovf_q;
   assign kbd_ascii = count_q != '0 ? mem_q[rd_ptr_q] : 8'h00;
endmodule
